// File: rtl/minv_mdiv_pkg.sv
// Shared encodings for the modular inverse / division sequencer:
// state codes, datapath op codes, register-write bit positions and width helpers.
package minv_mdiv_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CHECK  = 4'd1,
    S_U_HALF = 4'd2,
    S_X1_ADJ = 4'd3,
    S_V_HALF = 4'd4,
    S_X2_ADJ = 4'd5,
    S_SUB_UV = 4'd6,
    S_SUB_VU = 4'd7,
    S_SUB_X  = 4'd8,
    S_FIX_X  = 4'd9,
    S_DONE   = 4'd10,
    S_ERR    = 4'd11
  } state_e;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SHR_U   = 3'd1;
  localparam logic [2:0] OP_SHR_V   = 3'd2;
  localparam logic [2:0] OP_ADD_P   = 3'd3;
  localparam logic [2:0] OP_SUB_UV  = 3'd4;
  localparam logic [2:0] OP_SUB_VU  = 3'd5;
  localparam logic [2:0] OP_SUB_X12 = 3'd6;
  localparam logic [2:0] OP_SUB_X21 = 3'd7;

  localparam int WR_U  = 0;
  localparam int WR_V  = 1;
  localparam int WR_X1 = 2;
  localparam int WR_X2 = 3;
  localparam int WR_T  = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic logic is_multi(input state_e s);
    case (s)
      S_X1_ADJ, S_X2_ADJ, S_SUB_UV, S_SUB_VU, S_SUB_X, S_FIX_X: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/minv_dig_cnt.sv
// Digit index counter for digit-serial operations: clear wins over enable,
// wraps after NDIG-1 and flags the last digit.
module minv_dig_cnt
  import minv_mdiv_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  output logic [cnt_w(NDIG)-1:0]    cnt,
  output logic                      last
);

  localparam int CW = cnt_w(NDIG);
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/minv_mdiv_seq.sv
// Control sequencer for a digit-serial binary extended-Euclid datapath that
// computes modular inverse (x1 = 1) or modular division (x1 = numerator).
module minv_mdiv_seq
  import minv_mdiv_pkg::*;
#(
  parameter int W        = 256,
  parameter int D        = 16,
  parameter int ITER_MAX = 2 * W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      abort,
  input  logic                      u_is1,
  input  logic                      v_is1,
  input  logic                      u_lsb,
  input  logic                      v_lsb,
  input  logic                      x1_lsb,
  input  logic                      x2_lsb,
  input  logic                      diff_neg,
  input  logic                      x_neg,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      init_ld,
  output logic                      init_x1_sel,
  output logic [2:0]                op,
  output logic [4:0]                wr_en,
  output logic                      shr_en,
  output logic                      carry_first,
  output logic [cnt_w(W/D)-1:0]     dig_cnt,
  output logic                      res_sel,
  output logic [3:0]                state
);

  localparam int NDIG = W / D;
  localparam int IW   = cnt_w(ITER_MAX + 1);
  localparam logic [IW-1:0] IMAX = IW'(ITER_MAX);

  generate
    if ((D <= 0) || (W % D != 0)) begin : g_bad_width
      $error("minv_mdiv_seq: W must be a multiple of D");
    end
  endgenerate

  state_e          state_q, state_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic            dir_q, dir_d;
  logic            res_sel_q, res_sel_d;

  logic [cnt_w(NDIG)-1:0] dig_cnt_w;
  logic            dig_last;
  logic            cnt_clr;
  logic            cnt_en;

  logic [2:0]      op_c;
  logic [4:0]      wr_c;
  logic            shr_c, done_c, err_c, init_c;

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    dir_d     = dir_q;
    res_sel_d = res_sel_q;
    op_c      = OP_NOP;
    wr_c      = '0;
    shr_c     = 1'b0;
    done_c    = 1'b0;
    err_c     = 1'b0;
    init_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CHECK;
          iter_d    = '0;
          dir_d     = 1'b0;
          res_sel_d = 1'b0;
          init_c    = 1'b1;
        end
      end
      S_CHECK: begin
        if (iter_q == IMAX) begin
          state_d = S_ERR;
        end else if (u_is1) begin
          state_d   = S_DONE;
          res_sel_d = 1'b0;
        end else if (v_is1) begin
          state_d   = S_DONE;
          res_sel_d = 1'b1;
        end else if (!u_lsb && !v_lsb) begin
          state_d = S_ERR;       // gcd(u,v) even: no inverse exists
        end else if (!u_lsb) begin
          state_d = S_U_HALF;
        end else if (!v_lsb) begin
          state_d = S_V_HALF;
        end else begin
          state_d = S_SUB_UV;
        end
      end
      S_U_HALF: begin
        op_c       = OP_SHR_U;
        wr_c[WR_U] = 1'b1;
        shr_c      = 1'b1;
        if (x1_lsb) begin
          state_d = S_X1_ADJ;
        end else begin
          wr_c[WR_X1] = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_X1_ADJ: begin
        op_c        = OP_ADD_P;
        wr_c[WR_X1] = 1'b1;
        if (dig_last) begin
          shr_c   = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_V_HALF: begin
        op_c       = OP_SHR_V;
        wr_c[WR_V] = 1'b1;
        shr_c      = 1'b1;
        if (x2_lsb) begin
          state_d = S_X2_ADJ;
        end else begin
          wr_c[WR_X2] = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_X2_ADJ: begin
        op_c        = OP_ADD_P;
        wr_c[WR_X2] = 1'b1;
        if (dig_last) begin
          shr_c   = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_SUB_UV: begin
        op_c       = OP_SUB_UV;
        wr_c[WR_T] = 1'b1;
        if (dig_last) begin
          if (diff_neg) begin
            dir_d   = 1'b1;
            state_d = S_SUB_VU;
          end else begin
            // u >= v: commit the trial difference held in t into u
            wr_c       = '0;
            wr_c[WR_U] = 1'b1;
            dir_d      = 1'b0;
            state_d    = S_SUB_X;
          end
        end
      end
      S_SUB_VU: begin
        op_c       = OP_SUB_VU;
        wr_c[WR_V] = 1'b1;
        dir_d      = 1'b1;
        if (dig_last) state_d = S_SUB_X;
      end
      S_SUB_X: begin
        if (dir_q) begin
          op_c        = OP_SUB_X21;
          wr_c[WR_X2] = 1'b1;
        end else begin
          op_c        = OP_SUB_X12;
          wr_c[WR_X1] = 1'b1;
        end
        if (dig_last) state_d = x_neg ? S_FIX_X : S_CHECK;
      end
      S_FIX_X: begin
        op_c                         = OP_ADD_P;
        wr_c[dir_q ? WR_X2 : WR_X1]  = 1'b1;
        if (dig_last) state_d = S_CHECK;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      op_c    = OP_NOP;
      wr_c    = '0;
      shr_c   = 1'b0;
      done_c  = 1'b0;
      err_c   = 1'b0;
    end

    // CHECK never loops on itself, so landing there is always a fresh entry.
    if ((state_d == S_CHECK) && (iter_d != IMAX)) begin
      iter_d = iter_d + 1'b1;
    end
  end

  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = is_multi(state_q);

  minv_dig_cnt #(
    .NDIG (NDIG)
  ) u_dig_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (dig_cnt_w),
    .last (dig_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      iter_q    <= '0;
      dir_q     <= 1'b0;
      res_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      dir_q     <= dir_d;
      res_sel_q <= res_sel_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_c;
  assign err         = err_c;
  assign init_ld     = init_c & rst;
  assign init_x1_sel = init_c & rst & mode;
  assign op          = op_c;
  assign wr_en       = wr_c;
  assign shr_en      = shr_c;
  assign carry_first = is_multi(state_q) & (dig_cnt_w == '0) & ~abort;
  assign dig_cnt     = dig_cnt_w;
  assign res_sel     = done_c & res_sel_q;
  assign state       = state_q;

endmodule

// File: tb/tb_minv_mdiv_seq.sv
// Directed bench for minv_mdiv_seq (W=16, D=4, ITER_MAX=4); expected output
// vectors are queued per step and popped against the sampled DUT outputs.
module tb_minv_mdiv_seq;
  import minv_mdiv_pkg::*;

  logic clk, rst, start, mode, abort;
  logic u_is1, v_is1, u_lsb, v_lsb, x1_lsb, x2_lsb, diff_neg, x_neg;
  logic busy, done, err, init_ld, init_x1_sel, shr_en, carry_first, res_sel;
  logic [2:0] op;
  logic [4:0] wr_en;
  logic [1:0] dig_cnt;
  logic [3:0] state;

  localparam logic [4:0] WU = 5'b00001, WV = 5'b00010, WX1 = 5'b00100,
                         WX2 = 5'b01000, WT = 5'b10000;

  typedef struct {
    string      tag;
    logic [21:0] val;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  minv_mdiv_seq #(.W(16), .D(4), .ITER_MAX(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .u_is1(u_is1), .v_is1(v_is1), .u_lsb(u_lsb), .v_lsb(v_lsb),
    .x1_lsb(x1_lsb), .x2_lsb(x2_lsb), .diff_neg(diff_neg), .x_neg(x_neg),
    .busy(busy), .done(done), .err(err), .init_ld(init_ld),
    .init_x1_sel(init_x1_sel), .op(op), .wr_en(wr_en), .shr_en(shr_en),
    .carry_first(carry_first), .dig_cnt(dig_cnt), .res_sel(res_sel),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] obs;
  assign obs = {busy, done, err, init_ld, init_x1_sel, op, wr_en, shr_en,
                carry_first, dig_cnt, res_sel, state};

  function automatic logic [21:0] ev(input logic [3:0] st, input logic [2:0] o = 3'd0,
                                     input logic [4:0] w = 5'd0, input logic s = 1'b0,
                                     input logic cf = 1'b0, input logic [1:0] dc = 2'd0,
                                     input logic dn = 1'b0, input logic er = 1'b0,
                                     input logic rs = 1'b0, input logic il = 1'b0,
                                     input logic ix = 1'b0);
    return {(st != 4'd0), dn, er, il, ix, o, w, s, cf, dc, rs, st};
  endfunction

  task automatic push_exp(input string tag, input logic [21:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (obs === e.val) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
    $display("[TB] %s obs=%h exp=%h", e.tag, obs, e.val);
  endtask

  task automatic chk_now(input string tag, input logic [21:0] val);
    push_exp(tag, val);
    pop_cmp();
  endtask

  // Inputs are already applied; sample on the falling edge, then advance.
  task automatic cyc(input string tag, input logic [21:0] val);
    push_exp(tag, val);
    @(negedge clk);
    pop_cmp();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op(input string tag, input logic m);
    start = 1'b1;
    mode  = m;
    cyc(tag, ev(S_IDLE, 3'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, m));
    start = 1'b0;
    mode  = 1'b0;
  endtask

  task automatic finish_done(input string tag, input logic rs);
    u_is1 = 1'b1;
    cyc({tag, "_check"}, ev(S_CHECK));
    cyc({tag, "_done"}, ev(S_DONE, 3'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, rs));
    cyc({tag, "_idle"}, ev(S_IDLE));
    u_is1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b1; mode = 1'b1; abort = 1'b0;
    u_is1 = 1'b0; v_is1 = 1'b0; u_lsb = 1'b1; v_lsb = 1'b1;
    x1_lsb = 1'b0; x2_lsb = 1'b0; diff_neg = 1'b0; x_neg = 1'b0;

    // Reset: outputs all zero even with start held high
    #2;
    chk_now("rst_async", 22'd0);
    @(posedge clk); #1;
    chk_now("rst_hold", 22'd0);

    // u already 1: done with result in x1
    rst = 1'b1; u_is1 = 1'b1;
    begin_op("u1_idle", 1'b1);
    cyc("u1_check", ev(S_CHECK));
    cyc("u1_done", ev(S_DONE, 3'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1));
    cyc("u1_idle_after", ev(S_IDLE));
    u_is1 = 1'b0;

    // v already 1: done with result in x2
    v_is1 = 1'b1;
    begin_op("v1_idle", 1'b0);
    cyc("v1_check", ev(S_CHECK));
    cyc("v1_done", ev(S_DONE, 3'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1));
    cyc("v1_idle_after", ev(S_IDLE));
    v_is1 = 1'b0;

    // both even: error
    u_lsb = 1'b0; v_lsb = 1'b0;
    begin_op("even_idle", 1'b0);
    cyc("even_check", ev(S_CHECK));
    cyc("even_err", ev(S_ERR, 3'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
    cyc("even_idle_after", ev(S_IDLE));

    // u < v: SUB_UV -> SUB_VU -> SUB_X using x2
    u_lsb = 1'b1; v_lsb = 1'b1;
    begin_op("neg_idle", 1'b0);
    cyc("neg_check", ev(S_CHECK));
    for (int d = 0; d < 4; d++) begin
      diff_neg = (d == 3);
      cyc($sformatf("neg_subuv_d%0d", d), ev(S_SUB_UV, 3'd4, WT, 1'b0, d == 0, 2'(d)));
    end
    diff_neg = 1'b0;
    for (int d = 0; d < 4; d++)
      cyc($sformatf("neg_subvu_d%0d", d), ev(S_SUB_VU, 3'd5, WV, 1'b0, d == 0, 2'(d)));
    for (int d = 0; d < 4; d++)
      cyc($sformatf("neg_subx_d%0d", d), ev(S_SUB_X, 3'd7, WX2, 1'b0, d == 0, 2'(d)));
    finish_done("neg", 1'b0);

    // u >= v: commit to u, SUB_X on x1 goes negative -> FIX_X
    begin_op("pos_idle", 1'b0);
    cyc("pos_check", ev(S_CHECK));
    for (int d = 0; d < 4; d++)
      cyc($sformatf("pos_subuv_d%0d", d),
          ev(S_SUB_UV, 3'd4, (d == 3) ? WU : WT, 1'b0, d == 0, 2'(d)));
    for (int d = 0; d < 4; d++) begin
      x_neg = (d == 3);
      cyc($sformatf("pos_subx_d%0d", d), ev(S_SUB_X, 3'd6, WX1, 1'b0, d == 0, 2'(d)));
    end
    x_neg = 1'b0;
    for (int d = 0; d < 4; d++)
      cyc($sformatf("pos_fix_d%0d", d), ev(S_FIX_X, 3'd3, WX1, 1'b0, d == 0, 2'(d)));
    finish_done("pos", 1'b0);

    // v even, x2 odd: V_HALF then X2_ADJ with shift on last digit
    v_lsb = 1'b0; x2_lsb = 1'b1;
    begin_op("x2a_idle", 1'b0);
    cyc("x2a_check", ev(S_CHECK));
    cyc("x2a_vhalf", ev(S_V_HALF, 3'd2, WV, 1'b1));
    for (int d = 0; d < 4; d++)
      cyc($sformatf("x2a_adj_d%0d", d), ev(S_X2_ADJ, 3'd3, WX2, d == 3, d == 0, 2'(d)));
    finish_done("x2a", 1'b0);

    // iteration limit: 4th CHECK entry errors out
    x2_lsb = 1'b0;
    begin_op("iter_idle", 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("iter_check%0d", k), ev(S_CHECK));
      cyc($sformatf("iter_vhalf%0d", k), ev(S_V_HALF, 3'd2, WV | WX2, 1'b1));
    end
    cyc("iter_check3", ev(S_CHECK));
    cyc("iter_err", ev(S_ERR, 3'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
    cyc("iter_idle_after", ev(S_IDLE));

    // u even, x1 even: U_HALF halves u and x1 together
    u_lsb = 1'b0; v_lsb = 1'b1; x1_lsb = 1'b0;
    begin_op("uh_idle", 1'b0);
    cyc("uh_check", ev(S_CHECK));
    cyc("uh_uhalf", ev(S_U_HALF, 3'd1, WU | WX1, 1'b1));
    finish_done("uh", 1'b0);

    // abort in X1_ADJ digit 2, then immediate restart
    x1_lsb = 1'b1;
    begin_op("ab_idle", 1'b0);
    cyc("ab_check", ev(S_CHECK));
    cyc("ab_uhalf", ev(S_U_HALF, 3'd1, WU, 1'b1));
    cyc("ab_adj_d0", ev(S_X1_ADJ, 3'd3, WX1, 1'b0, 1'b1, 2'd0));
    cyc("ab_adj_d1", ev(S_X1_ADJ, 3'd3, WX1, 1'b0, 1'b0, 2'd1));
    abort = 1'b1;
    cyc("ab_abort", ev(S_X1_ADJ, 3'd0, 5'd0, 1'b0, 1'b0, 2'd2));
    abort = 1'b0;
    u_is1 = 1'b1;
    begin_op("ab_restart", 1'b1);
    cyc("ab2_check", ev(S_CHECK));
    cyc("ab2_done", ev(S_DONE, 3'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1));
    cyc("ab2_idle", ev(S_IDLE));
    u_is1 = 1'b0;

    // reset asserted mid SUB_X digit 1 clears everything without a clock
    u_lsb = 1'b1; v_lsb = 1'b1;
    begin_op("rs_idle", 1'b0);
    cyc("rs_check", ev(S_CHECK));
    for (int d = 0; d < 4; d++)
      cyc($sformatf("rs_subuv_d%0d", d),
          ev(S_SUB_UV, 3'd4, (d == 3) ? WU : WT, 1'b0, d == 0, 2'(d)));
    cyc("rs_subx_d0", ev(S_SUB_X, 3'd6, WX1, 1'b0, 1'b1, 2'd0));
    chk_now("rs_subx_d1", ev(S_SUB_X, 3'd6, WX1, 1'b0, 1'b0, 2'd1));
    rst = 1'b0;
    #1;
    chk_now("rs_async_clear", 22'd0);
    @(posedge clk); #1;
    chk_now("rs_hold", 22'd0);
    rst = 1'b1;
    cyc("rs_idle_after", ev(S_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
